// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: reads reg_file, resolves MEM/WB bypasses, stalls on
// load-use hazards through a one-entry load scoreboard, and presents the
// resolved instruction to execute through a valid/ready output register.
module operand_fetch_stage #(
    parameter int PAYLOAD_W       = 64,
    parameter int LOAD_USE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic                 in_use_rs1,
    input  logic                 in_use_rs2,
    input  logic [4:0]           in_rd,
    input  logic                 in_reg_write,
    input  logic                 in_is_load,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 flush,
    output logic [4:0]           rf_rd_reg_1,
    output logic [4:0]           rf_rd_reg_2,
    input  logic [31:0]          rf_rd_data_1,
    input  logic [31:0]          rf_rd_data_2,
    input  logic                 mem_fwd_en,
    input  logic [4:0]           mem_fwd_reg,
    input  logic [31:0]          mem_fwd_data,
    input  logic                 wb_wr_en,
    input  logic [4:0]           wb_wr_reg,
    input  logic [31:0]          wb_wr_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_rs1_data,
    output logic [31:0]          out_rs2_data,
    output logic [4:0]           out_rd,
    output logic                 out_reg_write,
    output logic                 out_is_load,
    output logic [PAYLOAD_W-1:0] out_payload
);

    // Bypass priority: x0 is hard zero, then MEM, then WB, then fallback value.
    function automatic logic [31:0] bypass(
        input logic [4:0]  idx,
        input logic [31:0] fallback,
        input logic        m_en,
        input logic [4:0]  m_reg,
        input logic [31:0] m_data,
        input logic        w_en,
        input logic [4:0]  w_reg,
        input logic [31:0] w_data
    );
        logic [31:0] r;
        r = fallback;
        if (idx == 5'd0)
            r = '0;
        else if (m_en && (m_reg == idx))
            r = m_data;
        else if (w_en && (w_reg == idx))
            r = w_data;
        return r;
    endfunction

    logic [4:0]  held_rs1;
    logic [4:0]  held_rs2;
    logic        sb_valid;
    logic [4:0]  sb_rd;
    logic [1:0]  sb_cnt;
    logic        hazard;
    logic        fire;
    logic        load_sets_sb;
    logic [31:0] res_rs1;
    logic [31:0] res_rs2;
    logic [31:0] snoop_rs1;
    logic [31:0] snoop_rs2;

    assign rf_rd_reg_1 = in_rs1;
    assign rf_rd_reg_2 = in_rs2;

    // Operand resolution for the incoming instruction and snooping for the held one.
    always_comb begin
        res_rs1   = bypass(in_rs1, rf_rd_data_1, mem_fwd_en, mem_fwd_reg, mem_fwd_data,
                           wb_wr_en, wb_wr_reg, wb_wr_data);
        res_rs2   = bypass(in_rs2, rf_rd_data_2, mem_fwd_en, mem_fwd_reg, mem_fwd_data,
                           wb_wr_en, wb_wr_reg, wb_wr_data);
        snoop_rs1 = bypass(held_rs1, out_rs1_data, mem_fwd_en, mem_fwd_reg, mem_fwd_data,
                           wb_wr_en, wb_wr_reg, wb_wr_data);
        snoop_rs2 = bypass(held_rs2, out_rs2_data, mem_fwd_en, mem_fwd_reg, mem_fwd_data,
                           wb_wr_en, wb_wr_reg, wb_wr_data);
    end

    // Load-use hazard detection and handshake.
    always_comb begin
        hazard = in_valid && sb_valid && (sb_rd != 5'd0) &&
                 ((in_use_rs1 && (in_rs1 == sb_rd)) || (in_use_rs2 && (in_rs2 == sb_rd)));
        in_ready     = (!out_valid || out_ready) && !hazard && !flush;
        fire         = in_valid && in_ready;
        load_sets_sb = fire && in_is_load && in_reg_write && (in_rd != 5'd0);
    end

    // Output register: capture on fire, bubble when drained, snoop operands while held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_rs1_data  <= '0;
            out_rs2_data  <= '0;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
            out_is_load   <= 1'b0;
            out_payload   <= '0;
            held_rs1      <= '0;
            held_rs2      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (fire) begin
            out_valid     <= 1'b1;
            out_rs1_data  <= res_rs1;
            out_rs2_data  <= res_rs2;
            out_rd        <= in_rd;
            out_reg_write <= in_reg_write;
            out_is_load   <= in_is_load;
            out_payload   <= in_payload;
            held_rs1      <= in_rs1;
            held_rs2      <= in_rs2;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else if (out_valid) begin
            out_rs1_data <= snoop_rs1;
            out_rs2_data <= snoop_rs2;
        end
    end

    // Load scoreboard: a new load overwrites the entry, otherwise count down on advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_valid <= 1'b0;
            sb_rd    <= '0;
            sb_cnt   <= '0;
        end else if (flush) begin
            sb_valid <= 1'b0;
            sb_cnt   <= '0;
        end else if (load_sets_sb) begin
            sb_valid <= 1'b1;
            sb_rd    <= in_rd;
            sb_cnt   <= 2'(LOAD_USE_CYCLES);
        end else if (sb_valid && out_ready) begin
            if (sb_cnt <= 2'd1) begin
                sb_valid <= 1'b0;
                sb_cnt   <= '0;
            end else begin
                sb_cnt <= sb_cnt - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed self-checking bench for operand_fetch_stage.
module tb_operand_fetch_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic        in_use_rs1;
    logic        in_use_rs2;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        in_is_load;
    logic [63:0] in_payload;
    logic        flush;
    logic [4:0]  rf_rd_reg_1;
    logic [4:0]  rf_rd_reg_2;
    logic [31:0] rf_rd_data_1;
    logic [31:0] rf_rd_data_2;
    logic        mem_fwd_en;
    logic [4:0]  mem_fwd_reg;
    logic [31:0] mem_fwd_data;
    logic        wb_wr_en;
    logic [4:0]  wb_wr_reg;
    logic [31:0] wb_wr_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rs1_data;
    logic [31:0] out_rs2_data;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_is_load;
    logic [63:0] out_payload;

    int checks;
    int errors;

    operand_fetch_stage #(
        .PAYLOAD_W(64),
        .LOAD_USE_CYCLES(1)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_is_load(in_is_load),
        .in_payload(in_payload), .flush(flush),
        .rf_rd_reg_1(rf_rd_reg_1), .rf_rd_reg_2(rf_rd_reg_2),
        .rf_rd_data_1(rf_rd_data_1), .rf_rd_data_2(rf_rd_data_2),
        .mem_fwd_en(mem_fwd_en), .mem_fwd_reg(mem_fwd_reg), .mem_fwd_data(mem_fwd_data),
        .wb_wr_en(wb_wr_en), .wb_wr_reg(wb_wr_reg), .wb_wr_data(wb_wr_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_is_load(out_is_load),
        .out_payload(out_payload)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic u1, input logic u2, input logic [4:0] rd,
                             input logic wr, input logic ld, input logic [63:0] pl);
        in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_use_rs1 = u1; in_use_rs2 = u2;
        in_rd = rd; in_reg_write = wr; in_is_load = ld; in_payload = pl;
    endtask

    task automatic drain;
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        mem_fwd_en = 1'b0; wb_wr_en = 1'b0;
        tick; tick;
    endtask

    task automatic test_reset;
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_payload !== 64'h0) begin errors++; $display("FAIL reset_payload: got %h expected 0", out_payload); end
        checks++; if (out_rs1_data !== 32'h0 || out_rd !== 5'd0) begin errors++; $display("FAIL reset_fields: got rs1=%h rd=%0d expected 0/0", out_rs1_data, out_rd); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        #9 rst = 1'b0;
        tick;
    endtask

    task automatic test_bypass;
        out_ready = 1'b1;
        // x0 never forwarded from MEM/WB or reg_file
        set_instr(5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 64'hB0);
        mem_fwd_en = 1'b1; mem_fwd_reg = 5'd0; mem_fwd_data = 32'hDEAD;
        wb_wr_en = 1'b1; wb_wr_reg = 5'd0; wb_wr_data = 32'hBEEF;
        rf_rd_data_1 = 32'h1234; rf_rd_data_2 = 32'h1234;
        tick;
        checks++; if (out_rs1_data !== 32'h0 || out_rs2_data !== 32'h0) begin errors++; $display("FAIL x0_zero: got %h/%h expected 0/0", out_rs1_data, out_rs2_data); end
        // MEM beats WB beats reg_file
        set_instr(5'd0, 5'd5, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 64'hB1);
        mem_fwd_reg = 5'd5; mem_fwd_data = 32'h11;
        wb_wr_reg = 5'd5; wb_wr_data = 32'h22;
        rf_rd_data_1 = 32'hDEAD; rf_rd_data_2 = 32'h33;
        #1;
        checks++; if (rf_rd_reg_2 !== 5'd5 || rf_rd_reg_1 !== 5'd0) begin errors++; $display("FAIL rf_addr: got %0d/%0d expected 0/5", rf_rd_reg_1, rf_rd_reg_2); end
        tick;
        checks++; if (out_rs1_data !== 32'h0 || out_rs2_data !== 32'h11) begin errors++; $display("FAIL mem_priority: got %h/%h expected 0/11", out_rs1_data, out_rs2_data); end
        checks++; if (out_valid !== 1'b1 || out_payload !== 64'hB1 || out_rd !== 5'd2) begin errors++; $display("FAIL bypass_fields: got v=%b pl=%h rd=%0d expected 1/b1/2", out_valid, out_payload, out_rd); end
        mem_fwd_en = 1'b0;
        tick;
        checks++; if (out_rs2_data !== 32'h22) begin errors++; $display("FAIL wb_priority: got %h expected 22", out_rs2_data); end
        wb_wr_en = 1'b0;
        tick;
        checks++; if (out_rs2_data !== 32'h33) begin errors++; $display("FAIL rf_fallback: got %h expected 33", out_rs2_data); end
        drain;
    endtask

    task automatic test_load_use(input logic use1);
        out_ready = 1'b1;
        rf_rd_data_1 = 32'h5; rf_rd_data_2 = 32'h6;
        set_instr(5'd1, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 64'h10);
        tick;
        checks++; if (out_valid !== 1'b1 || out_is_load !== 1'b1) begin errors++; $display("FAIL load_capture: got v=%b ld=%b expected 1/1", out_valid, out_is_load); end
        set_instr(5'd7, 5'd2, use1, 1'b1, 5'd8, 1'b1, 1'b0, 64'h11);
        #1;
        checks++; if (in_ready !== !use1) begin errors++; $display("FAIL load_use_ready: got %b expected %b", in_ready, !use1); end
        if (use1) begin
            tick;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL load_use_bubble: got %b expected 0", out_valid); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL load_use_release: got %b expected 1", in_ready); end
            mem_fwd_en = 1'b1; mem_fwd_reg = 5'd7; mem_fwd_data = 32'h77;
        end
        tick;
        checks++; if (out_valid !== 1'b1 || out_rd !== 5'd8 || out_payload !== 64'h11) begin errors++; $display("FAIL load_use_issue: got v=%b rd=%0d pl=%h expected 1/8/11", out_valid, out_rd, out_payload); end
        if (use1) begin
            checks++; if (out_rs1_data !== 32'h77) begin errors++; $display("FAIL load_use_fwd: got %h expected 77", out_rs1_data); end
        end
        drain;
    endtask

    task automatic test_snoop;
        out_ready = 1'b1;
        rf_rd_data_1 = 32'h44; rf_rd_data_2 = 32'h100;
        set_instr(5'd4, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 64'hCAFE);
        tick;
        checks++; if (out_rs2_data !== 32'h100) begin errors++; $display("FAIL snoop_capture: got %h expected 100", out_rs2_data); end
        in_valid = 1'b0; out_ready = 1'b0;
        mem_fwd_en = 1'b1; mem_fwd_reg = 5'd12; mem_fwd_data = 32'h999;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready: got %b expected 0", in_ready); end
        tick;
        mem_fwd_en = 1'b0;
        wb_wr_en = 1'b1; wb_wr_reg = 5'd9; wb_wr_data = 32'h200;
        tick;
        wb_wr_en = 1'b0; rf_rd_data_2 = 32'h555; rf_rd_data_1 = 32'h666;
        tick;
        checks++; if (out_rs2_data !== 32'h200) begin errors++; $display("FAIL snoop_rs2: got %h expected 200", out_rs2_data); end
        checks++; if (out_valid !== 1'b1 || out_rs1_data !== 32'h44 || out_rd !== 5'd10 || out_payload !== 64'hCAFE)
            begin errors++; $display("FAIL snoop_stable: got v=%b rs1=%h rd=%0d pl=%h expected 1/44/10/cafe", out_valid, out_rs1_data, out_rd, out_payload); end
        out_ready = 1'b1;
        tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL snoop_drain: got %b expected 0", out_valid); end
        drain;
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        rf_rd_data_2 = 32'h0;
        for (int i = 0; i < 10; i++) begin
            set_instr(5'd1, 5'd2, 1'b1, 1'b1, 5'(i + 1), 1'b1, 1'b0, 64'hA000 + 64'(i));
            rf_rd_data_1 = 32'(i * 3);
            tick;
            checks++; if (out_valid !== 1'b1 || out_payload !== 64'hA000 + 64'(i) || out_rs1_data !== 32'(i * 3))
                begin errors++; $display("FAIL throughput_%0d: got v=%b pl=%h rs1=%h expected 1/%h/%h", i, out_valid, out_payload, out_rs1_data, 64'hA000 + 64'(i), 32'(i * 3)); end
        end
        in_valid = 1'b0;
        tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL throughput_end: got %b expected 0", out_valid); end
        drain;
    endtask

    task automatic test_flush;
        out_ready = 1'b1;
        set_instr(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 64'h30);
        tick;
        out_ready = 1'b0; flush = 1'b1;
        set_instr(5'd3, 5'd2, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 64'h31);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
        tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
        checks++; if (dut.sb_valid !== 1'b0) begin errors++; $display("FAIL flush_sb_valid: got %b expected 0", dut.sb_valid); end
        flush = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_no_stall: got %b expected 1", in_ready); end
        tick;
        checks++; if (out_valid !== 1'b1 || out_rd !== 5'd11) begin errors++; $display("FAIL flush_reissue: got v=%b rd=%0d expected 1/11", out_valid, out_rd); end
        drain;
    endtask

    task automatic test_async_reset;
        out_ready = 1'b1;
        set_instr(5'd1, 5'd2, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 64'h60);
        tick;
        out_ready = 1'b0;
        set_instr(5'd6, 5'd2, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0, 64'h61);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_pre_stall: got %b expected 0", in_ready); end
        tick;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_hold: got %b expected 1", out_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_payload !== 64'h0 || out_rd !== 5'd0) begin errors++; $display("FAIL rst_async_out: got v=%b pl=%h rd=%0d expected 0/0/0", out_valid, out_payload, out_rd); end
        checks++; if (dut.sb_valid !== 1'b0) begin errors++; $display("FAIL rst_async_sb: got %b expected 0", dut.sb_valid); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        in_valid = 1'b0;
        tick;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_use_rs1 = 1'b0; in_use_rs2 = 1'b0;
        in_rd = '0; in_reg_write = 1'b0; in_is_load = 1'b0; in_payload = '0; flush = 1'b0;
        rf_rd_data_1 = '0; rf_rd_data_2 = '0; mem_fwd_en = 1'b0; mem_fwd_reg = '0; mem_fwd_data = '0;
        wb_wr_en = 1'b0; wb_wr_reg = '0; wb_wr_data = '0; out_ready = 1'b0;
        test_reset;
        test_bypass;
        test_load_use(1'b1);
        test_load_use(1'b0);
        test_snoop;
        test_back_to_back;
        test_flush;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode-to-execute operand stage of the riscv_32i pipeline, sitting directly upstream of reg_file.
- Drives reg_file read addresses from decoded rs1/rs2 and captures rd_data_1/rd_data_2 into a valid/ready output register.
- Bypasses results from the MEM and WB stages, and stalls on load-use hazards using a one-entry load scoreboard.
- Its output is consumed by the execute stage.

Parameters:
- PAYLOAD_W, 64, width of the opaque pass-through bundle (pc, imm, alu op); not interpreted by this block.
- LOAD_USE_CYCLES, 1, number of downstream advances before a load's rd becomes forwardable; legal range 1-3.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_rs1, in_rs2  in  5  source register indices.
- in_use_rs1, in_use_rs2  in  1  the instruction actually reads that source.
- in_rd  in  5  destination index.
- in_reg_write  in  1  the instruction writes rd.
- in_is_load  in  1  the instruction is a load.
- in_payload  in  PAYLOAD_W  pass-through bundle.
- flush  in  1  kill the held output and the scoreboard (branch redirect).
- rf_rd_reg_1, rf_rd_reg_2  out  5  reg_file read addresses; combinational copies of in_rs1 and in_rs2.
- rf_rd_data_1, rf_rd_data_2  in  32  reg_file combinational read data.
- mem_fwd_en  in  1  MEM-stage result is valid and writes a register.
- mem_fwd_reg  in  5  MEM-stage destination index.
- mem_fwd_data  in  32  MEM-stage result.
- wb_wr_en  in  1  WB write (same signals that drive reg_file wr_en).
- wb_wr_reg  in  5  WB destination index.
- wb_wr_data  in  32  WB write data.
- out_valid  out  1  registered instruction valid.
- out_ready  in  1  execute stage accepts.
- out_rs1_data, out_rs2_data  out  32  resolved operands.
- out_rd  out  5  registered destination index.
- out_reg_write  out  1  registered write flag.
- out_is_load  out  1  registered load flag.
- out_payload  out  PAYLOAD_W  registered pass-through bundle.

Behaviour:
- Reset (asynchronous, rst=1): all out_* = 0; scoreboard cleared (sb_valid=0, sb_cnt=0).
- Operand resolution, per source (combinational):
  - Index 0 always resolves to 32'h0 and is never forwarded.
  - Otherwise priority is: mem_fwd (en and reg match) > wb (wr_en and reg match) > rf_rd_data.
- Hazard: in_valid & sb_valid & sb_rd != 0 & ((in_use_rs1 & in_rs1 == sb_rd) | (in_use_rs2 & in_rs2 == sb_rd)).
- in_ready = (!out_valid | out_ready) & !hazard & !flush.
- Fire = in_valid & in_ready. On fire, all out_* capture the resolved values with out_valid=1; latency is one clock.
- No fire and out_ready=1: out_valid <= 0 (bubble). Other out_* fields are don't-care while out_valid=0.
- Hold (out_valid & !out_ready): out_* are stable, except held operands snoop every cycle.
  - If out_rd's sources matched a mem_fwd or wb write, the operand is updated using the same priority.
  - The held source indices are stored internally.
  - This prevents stale operands while EX is stalled.
- Load scoreboard:
  - On fire with in_is_load & in_reg_write & in_rd != 0: sb_valid=1, sb_rd=in_rd, sb_cnt=LOAD_USE_CYCLES.
  - Each cycle with sb_valid & out_ready (pipeline advances): sb_cnt decrements. At reaching 0, sb_valid clears on that edge.
  - A new load firing in the same cycle as a decrement overwrites the entry.
- Flush (synchronous, has priority over fire):
  - Next edge: out_valid=0, sb_valid=0. in_ready=0 during the flush cycle, so the input is dropped.
- Simultaneous fire and out_ready: the held output is consumed and the new one is captured on the same edge (full throughput, one per cycle).
- Reset mid-stall clears the hazard immediately (asynchronous), so in_ready rises combinationally after rst deasserts.

Test Plan:
- x0 / bypass priority:
  - Stimulus: rs1=0 with mem_fwd to x0=0xDEAD; rs2=5 with mem_fwd x5=0x11, wb x5=0x22, rf x5=0x33.
  - Response: out_rs1_data=0, out_rs2_data=0x11. Drop mem_fwd and the result is 0x22; drop wb as well and it is 0x33.
- Load-use stall:
  - Stimulus: fire a load with rd=7, then next instruction add rs1=7 (use_rs1=1), out_ready=1, LOAD_USE_CYCLES=1.
  - Response: in_ready=0 for exactly 1 cycle, one bubble (out_valid=0) emitted, then the add fires.
  - Same sequence with use_rs1=0: no stall.
- Back-pressure snoop:
  - Stimulus: capture rs2=9 with value 0x100; hold out_ready=0 for 3 cycles; during the hold, wb writes x9=0x200.
  - Response: out_rs2_data=0x200 when finally accepted. No other out_* field changes.
- Throughput:
  - Stimulus: 10 independent instructions, in_valid=out_ready=1 continuously.
  - Response: 10 consecutive out_valid cycles with payloads in order, and 1-cycle latency.
- Flush:
  - Stimulus: load rd=3 fires; assert flush next cycle with in_valid=1 and an instruction using x3.
  - Response: out_valid=0 after the edge, sb_valid=0, and the flushed-cycle instruction is not accepted. The following cycle accepts without stall.
- Async reset:
  - Stimulus: assert rst mid-hold with out_valid=1.
  - Response: out_valid=0 and sb_valid=0 immediately, without a clock edge.
